// File: rtl/riscv_pkg.sv
// Shared core types used by the unified-memory port arbiter.
package riscv_pkg;

    localparam int XLEN = 32;

    typedef enum logic [2:0] {
        MEM_B,
        MEM_H,
        MEM_W,
        MEM_BU,
        MEM_HU
    } mem_op_t;

    typedef enum logic [1:0] {
        ARB_IDLE,
        ARB_ISSUE,
        ARB_WAIT
    } arb_state_e;

    typedef enum logic {
        OWN_IF,
        OWN_D
    } arb_owner_e;

endpackage

// File: rtl/mem_arb_grant.sv
// Combinational IF/D grant with a starvation counter that forces IF to win
// after STARVE_LIMIT consecutive conflict losses.
module mem_arb_grant #(
    parameter int STARVE_LIMIT = 4
) (
    input  logic clk,
    input  logic reset,
    input  logic arb_en,
    input  logic if_valid,
    input  logic d_valid,
    output logic grant_if,
    output logic grant_d
);

    localparam int CW = (STARVE_LIMIT < 1) ? 1 : $clog2(STARVE_LIMIT + 1);
    localparam logic [CW-1:0] LIMIT = CW'(STARVE_LIMIT);

    logic [CW-1:0] starve_cnt;
    logic          conflict;

    always_comb begin
        conflict = if_valid && d_valid;
        grant_if = 1'b0;
        grant_d  = 1'b0;
        if (arb_en) begin
            if (conflict) begin
                grant_if = (starve_cnt == LIMIT);
                grant_d  = !grant_if;
            end else begin
                grant_if = if_valid;
                grant_d  = d_valid;
            end
        end
    end

    // D can only win a conflict while below the limit, so the increment saturates.
    always_ff @(posedge clk) begin
        if (reset) begin
            starve_cnt <= '0;
        end else if (grant_if) begin
            starve_cnt <= '0;
        end else if (grant_d && conflict && (starve_cnt != LIMIT)) begin
            starve_cnt <= starve_cnt + 1'b1;
        end
    end

endmodule

// File: rtl/mem_port_arbiter.sv
// Shares one single-port memory between fetch and data requesters, one
// transaction in flight. Optional counters enabled by MEM_ARB_STATS_EN.
module mem_port_arbiter
    import riscv_pkg::*;
#(
    parameter int ADDR_WIDTH   = 32,
    parameter int STARVE_LIMIT = 4
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  if_req_valid,
    input  logic [ADDR_WIDTH-1:0] if_req_addr,
    output logic                  if_req_ready,
    output logic                  if_rsp_valid,
    output logic [XLEN-1:0]       if_rsp_rdata,
    input  logic                  d_req_valid,
    input  logic                  d_req_we,
    input  logic [ADDR_WIDTH-1:0] d_req_addr,
    input  logic [XLEN-1:0]       d_req_wdata,
    input  mem_op_t               d_req_mem_op,
    output logic                  d_req_ready,
    output logic                  d_rsp_valid,
    output logic [XLEN-1:0]       d_rsp_rdata,
    output logic                  mem_req_valid,
    output logic                  mem_req_we,
    output logic [ADDR_WIDTH-1:0] mem_req_addr,
    output logic [XLEN-1:0]       mem_req_wdata,
    output mem_op_t               mem_req_mem_op,
    input  logic                  mem_req_ready,
    input  logic                  mem_rsp_valid,
    input  logic [XLEN-1:0]       mem_rsp_rdata
`ifdef MEM_ARB_STATS_EN
    ,
    output logic [31:0]           stat_if_grants,
    output logic [31:0]           stat_d_grants,
    output logic [31:0]           stat_conflicts
`endif
);

    arb_state_e state, state_nx;
    arb_owner_e owner;
    logic       arb_en;
    logic       grant_if, grant_d;

    assign arb_en = (state == ARB_IDLE) && !reset;

    mem_arb_grant #(
        .STARVE_LIMIT(STARVE_LIMIT)
    ) u_grant (
        .clk      (clk),
        .reset    (reset),
        .arb_en   (arb_en),
        .if_valid (if_req_valid),
        .d_valid  (d_req_valid),
        .grant_if (grant_if),
        .grant_d  (grant_d)
    );

    // Outputs are forced low while reset is held, whatever the old state.
    always_comb begin
        state_nx      = state;
        if_req_ready  = 1'b0;
        d_req_ready   = 1'b0;
        mem_req_valid = 1'b0;
        if_rsp_valid  = 1'b0;
        d_rsp_valid   = 1'b0;
        if (!reset) begin
            case (state)
                ARB_IDLE: begin
                    if_req_ready = grant_if;
                    d_req_ready  = grant_d;
                    if (grant_if || grant_d) state_nx = ARB_ISSUE;
                end
                ARB_ISSUE: begin
                    mem_req_valid = 1'b1;
                    if (mem_req_ready) state_nx = ARB_WAIT;
                end
                ARB_WAIT: begin
                    if (mem_rsp_valid) begin
                        if_rsp_valid = (owner == OWN_IF);
                        d_rsp_valid  = (owner == OWN_D);
                        state_nx     = ARB_IDLE;
                    end
                end
                default: state_nx = ARB_IDLE;
            endcase
        end
    end

    assign if_rsp_rdata = mem_rsp_rdata;
    assign d_rsp_rdata  = mem_rsp_rdata;

    always_ff @(posedge clk) begin
        if (reset) state <= ARB_IDLE;
        else       state <= state_nx;
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            owner          <= OWN_IF;
            mem_req_we     <= 1'b0;
            mem_req_addr   <= '0;
            mem_req_wdata  <= '0;
            mem_req_mem_op <= mem_op_t'(3'd0);
        end else if (grant_if) begin
            owner          <= OWN_IF;
            mem_req_we     <= 1'b0;
            mem_req_addr   <= if_req_addr;
            mem_req_wdata  <= '0;
            mem_req_mem_op <= MEM_W;
        end else if (grant_d) begin
            owner          <= OWN_D;
            mem_req_we     <= d_req_we;
            mem_req_addr   <= d_req_addr;
            mem_req_wdata  <= d_req_wdata;
            mem_req_mem_op <= d_req_mem_op;
        end
    end

`ifdef MEM_ARB_STATS_EN
    always_ff @(posedge clk) begin
        if (reset) begin
            stat_if_grants <= '0;
            stat_d_grants  <= '0;
            stat_conflicts <= '0;
        end else begin
            if (grant_if) stat_if_grants <= stat_if_grants + 32'd1;
            if (grant_d)  stat_d_grants  <= stat_d_grants + 32'd1;
            if (arb_en && if_req_valid && d_req_valid) stat_conflicts <= stat_conflicts + 32'd1;
        end
    end
`endif

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Random-stimulus scoreboard bench for mem_port_arbiter; stats checked when
// MEM_ARB_STATS_EN is defined.
module tb_mem_port_arbiter;
    import riscv_pkg::*;

    localparam int AW     = 32;
    localparam int SL     = 4;
    localparam int NCYC   = 3000;
    localparam int BOTH_N = 300;
    localparam int DRAIN  = 100;

    logic            clk = 1'b0;
    logic            reset = 1'b1;
    logic            if_req_valid = 1'b0;
    logic [AW-1:0]   if_req_addr = '0;
    logic            if_req_ready, if_rsp_valid;
    logic [XLEN-1:0] if_rsp_rdata;
    logic            d_req_valid = 1'b0, d_req_we = 1'b0;
    logic [AW-1:0]   d_req_addr = '0;
    logic [XLEN-1:0] d_req_wdata = '0;
    mem_op_t         d_req_mem_op = MEM_W;
    logic            d_req_ready, d_rsp_valid;
    logic [XLEN-1:0] d_rsp_rdata;
    logic            mem_req_valid, mem_req_we;
    logic [AW-1:0]   mem_req_addr;
    logic [XLEN-1:0] mem_req_wdata;
    mem_op_t         mem_req_mem_op;
    logic            mem_req_ready = 1'b0, mem_rsp_valid = 1'b0;
    logic [XLEN-1:0] mem_rsp_rdata = '0;
`ifdef MEM_ARB_STATS_EN
    logic [31:0]     stat_if_grants, stat_d_grants, stat_conflicts;
`endif

    mem_port_arbiter #(.ADDR_WIDTH(AW), .STARVE_LIMIT(SL)) dut (
        .clk(clk), .reset(reset),
        .if_req_valid(if_req_valid), .if_req_addr(if_req_addr), .if_req_ready(if_req_ready),
        .if_rsp_valid(if_rsp_valid), .if_rsp_rdata(if_rsp_rdata),
        .d_req_valid(d_req_valid), .d_req_we(d_req_we), .d_req_addr(d_req_addr),
        .d_req_wdata(d_req_wdata), .d_req_mem_op(d_req_mem_op), .d_req_ready(d_req_ready),
        .d_rsp_valid(d_rsp_valid), .d_rsp_rdata(d_rsp_rdata),
        .mem_req_valid(mem_req_valid), .mem_req_we(mem_req_we), .mem_req_addr(mem_req_addr),
        .mem_req_wdata(mem_req_wdata), .mem_req_mem_op(mem_req_mem_op),
        .mem_req_ready(mem_req_ready), .mem_rsp_valid(mem_rsp_valid), .mem_rsp_rdata(mem_rsp_rdata)
`ifdef MEM_ARB_STATS_EN
        , .stat_if_grants(stat_if_grants), .stat_d_grants(stat_d_grants), .stat_conflicts(stat_conflicts)
`endif
    );

    always #5 clk = ~clk;

    typedef struct {
        bit              is_d;
        bit              we;
        logic [AW-1:0]   addr;
        logic [XLEN-1:0] wdata;
        mem_op_t         op;
    } mreq_t;

    typedef struct {
        bit              is_d;
        logic [XLEN-1:0] rdata;
    } rsp_t;

    mreq_t mq[$];
    rsp_t  rq[$];
    int    total = 0;
    int    bad = 0;
    bit    rsp_real = 1'b0;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    // Reference model: one transaction at a time, D wins conflicts unless IF
    // has lost SL conflicts in a row.
    bit busy = 1'b0, issued = 1'b0, own_d = 1'b0;
    int starve = 0, n_if = 0, n_d = 0, n_cf = 0;

    always @(negedge clk) begin : model
        bit    exp_if, exp_d, exp_mv;
        mreq_t m;
        rsp_t  r;
        exp_if = 1'b0;
        exp_d  = 1'b0;
        exp_mv = 1'b0;
        if (reset) begin
            busy = 1'b0; issued = 1'b0; starve = 0;
            n_if = 0; n_d = 0; n_cf = 0;
            mq.delete();
            rq.delete();
        end else begin
`ifdef MEM_ARB_STATS_EN
            chk("stat_if_grants", stat_if_grants, n_if);
            chk("stat_d_grants", stat_d_grants, n_d);
            chk("stat_conflicts", stat_conflicts, n_cf);
`endif
            if (!busy) begin
                if (if_req_valid && d_req_valid) begin
                    n_cf++;
                    if (starve == SL) exp_if = 1'b1;
                    else              exp_d  = 1'b1;
                end else begin
                    exp_if = if_req_valid;
                    exp_d  = d_req_valid;
                end
                if (exp_if) begin
                    starve = 0; n_if++;
                    m = '{is_d: 1'b0, we: 1'b0, addr: if_req_addr, wdata: '0, op: MEM_W};
                    mq.push_back(m);
                    busy = 1'b1; own_d = 1'b0;
                end
                if (exp_d) begin
                    if (if_req_valid) starve++;
                    n_d++;
                    m = '{is_d: 1'b1, we: d_req_we, addr: d_req_addr, wdata: d_req_wdata, op: d_req_mem_op};
                    mq.push_back(m);
                    busy = 1'b1; own_d = 1'b1;
                end
            end else if (!issued) begin
                exp_mv = 1'b1;
                if (mem_req_ready) issued = 1'b1;
            end else if (rsp_real) begin
                r = '{is_d: own_d, rdata: mem_rsp_rdata};
                rq.push_back(r);
                busy = 1'b0; issued = 1'b0;
            end
        end
        chk("if_req_ready", if_req_ready, exp_if);
        chk("d_req_ready", d_req_ready, exp_d);
        chk("mem_req_valid", mem_req_valid, exp_mv);
    end

    // Monitor: pops expectations whenever the DUT presents a request or response.
    always begin : monitor
        mreq_t m;
        rsp_t  r;
        @(negedge clk);
        #1;
        if (mem_req_valid) begin
            if (mq.size() == 0) begin
                chk("mem_req_unexpected", mem_req_valid, 1'b0);
            end else begin
                m = mq[0];
                chk("mem_req_we", mem_req_we, m.we);
                chk("mem_req_addr", mem_req_addr, m.addr);
                chk("mem_req_mem_op", mem_req_mem_op, m.op);
                if (m.is_d) chk("mem_req_wdata", mem_req_wdata, m.wdata);
                if (mem_req_ready) void'(mq.pop_front());
            end
        end
        if (rq.size() > 0) begin
            r = rq.pop_front();
            chk("if_rsp_valid", if_rsp_valid, !r.is_d);
            chk("d_rsp_valid", d_rsp_valid, r.is_d);
            if (r.is_d) chk("d_rsp_rdata", d_rsp_rdata, r.rdata);
            else        chk("if_rsp_rdata", if_rsp_rdata, r.rdata);
        end else begin
            chk("if_rsp_quiet", if_rsp_valid, 1'b0);
            chk("d_rsp_quiet", d_rsp_valid, 1'b0);
        end
    end

    // Stimulus: requesters hold payload until accepted; memory stalls and
    // answers with random latency, plus stray responses when nothing is pending.
    initial begin : stim
        bit if_pend, d_pend, mem_out, both, drain;
        int dly;
        if_pend = 1'b0; d_pend = 1'b0; mem_out = 1'b0; dly = 0;
        for (int cyc = 0; cyc < NCYC; cyc++) begin
            @(posedge clk);
            #1;
            both  = (cyc < BOTH_N);
            drain = (cyc >= NCYC - DRAIN);
            reset = (cyc < 3) || (!both && !drain && mem_out && ($urandom_range(0, 30) == 0));
            if (reset) mem_out = 1'b0;
            if (!if_pend && !drain && (both || $urandom_range(0, 1) == 1)) begin
                if_pend     = 1'b1;
                if_req_addr = $urandom & 32'hFFFF_FFFC;
            end
            if (!d_pend && !drain && (both || $urandom_range(0, 1) == 1)) begin
                d_pend       = 1'b1;
                d_req_we     = 1'($urandom_range(0, 1));
                d_req_addr   = $urandom;
                d_req_wdata  = $urandom;
                d_req_mem_op = mem_op_t'($urandom_range(0, 4));
            end
            if_req_valid  = if_pend;
            d_req_valid   = d_pend;
            mem_req_ready = (both || drain) ? 1'b1 : ($urandom_range(0, 3) != 0);
            rsp_real      = 1'b0;
            mem_rsp_valid = 1'b0;
            mem_rsp_rdata = $urandom;
            if (mem_out) begin
                if (dly == 0) begin
                    mem_rsp_valid = 1'b1;
                    rsp_real      = 1'b1;
                    mem_out       = 1'b0;
                end else begin
                    dly--;
                end
            end else if (!both && !drain && $urandom_range(0, 9) == 0) begin
                mem_rsp_valid = 1'b1;
            end
            @(negedge clk);
            if (if_req_valid && if_req_ready) if_pend = 1'b0;
            if (d_req_valid && d_req_ready)   d_pend  = 1'b0;
            if (mem_req_valid && mem_req_ready) begin
                mem_out = 1'b1;
                dly     = (both || drain) ? 0 : $urandom_range(0, 3);
            end
        end
        @(posedge clk);
        #2;
        chk("req_queue_drained", mq.size(), 0);
        chk("rsp_queue_drained", rq.size(), 0);
        chk("if_req_drained", if_pend, 1'b0);
        chk("d_req_drained", d_pend, 1'b0);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
